// File: rtl/zone_dwell_detector.sv
// zone_dwell_detector: RGB565 colour-window hits binned into a zone grid,
// per-zone dwell tracking and UART report. Option: ZONE_DWELL_REPEAT_EN.
module zone_dwell_detector #(
  parameter int ZONE_COLS      = 4,
  parameter int ZONE_ROWS      = 3,
  parameter int ZONE_W_LOG2    = 7,
  parameter int ZONE_H_LOG2    = 7,
  parameter int R_MIN          = 24,
  parameter int G_MAX          = 25,
  parameter int B_MAX          = 12,
  parameter int HIT_MIN        = 64,
  parameter int DWELL_FRAMES   = 45,
  parameter int HOLDOFF_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  input  logic [9:0]                     x,
  input  logic [9:0]                     y,
  input  logic [15:0]                    rgb_data,
  input  logic                           frame_start,
  input  logic [ZONE_COLS*ZONE_ROWS-1:0] zone_en,
  input  logic                           tx_busy,
  output logic [7:0]                     tx_data,
  output logic                           tx_start,
  output logic [ZONE_COLS*ZONE_ROWS-1:0] active_mask
);

  localparam int N_ZONES = ZONE_COLS * ZONE_ROWS;
  localparam int IW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int HW = $clog2(HIT_MIN + 1);
  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam int OW = $clog2(HOLDOFF_FRAMES + 1);

  localparam logic [4:0]    R_LO      = 5'(R_MIN);
  localparam logic [5:0]    G_HI      = 6'(G_MAX);
  localparam logic [4:0]    B_HI      = 5'(B_MAX);
  localparam logic [9:0]    COLS      = 10'(ZONE_COLS);
  localparam logic [9:0]    ROWS      = 10'(ZONE_ROWS);
  localparam logic [HW-1:0] HIT_SAT   = HW'(HIT_MIN);
  localparam logic [DW-1:0] DWELL_END = DW'(DWELL_FRAMES);
  localparam logic [OW-1:0] HOLD_END  = OW'(HOLDOFF_FRAMES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  logic [4:0]    r;
  logic [5:0]    g;
  logic [4:0]    b;
  logic [9:0]    col;
  logic [9:0]    row;
  logic          pix_hit;
  logic [IW-1:0] pix_idx;
  logic          s1_hit;
  logic [IW-1:0] s1_idx;
  logic [HW-1:0] hit_cnt [N_ZONES];
  logic          frame_tick;
  logic [1:0]    state;
  logic [IW-1:0] cand;
  logic [IW-1:0] low_idx;
  logic [DW-1:0] dwell;
  logic [OW-1:0] holdoff;
  logic [OW-1:0] hold_nxt;

  assign r   = rgb_data[15:11];
  assign g   = rgb_data[10:5];
  assign b   = rgb_data[4:0];
  assign col = x >> ZONE_W_LOG2;
  assign row = y >> ZONE_H_LOG2;

  // Index fits IW bits whenever the pixel is inside the grid
  assign pix_idx = IW'(row) * IW'(ZONE_COLS) + IW'(col);
  assign pix_hit = pix_valid && (r >= R_LO) && (g <= G_HI) &&
                   (b <= B_HI) && (col < COLS) && (row < ROWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit <= 1'b0;
      s1_idx <= '0;
    end else begin
      s1_hit <= pix_hit;
      s1_idx <= pix_idx;
    end
  end

  // A stage-2 hit landing on the frame boundary is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int z = 0; z < N_ZONES; z++) hit_cnt[z] <= '0;
      active_mask <= '0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        for (int z = 0; z < N_ZONES; z++) begin
          active_mask[z] <= (hit_cnt[z] == HIT_SAT) && zone_en[z];
          hit_cnt[z]     <= '0;
        end
      end else if (s1_hit && hit_cnt[s1_idx] != HIT_SAT) begin
        hit_cnt[s1_idx] <= hit_cnt[s1_idx] + HW'(1);
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = N_ZONES - 1; i >= 0; i--)
      if (active_mask[i]) low_idx = IW'(i);
  end

  assign hold_nxt = (holdoff == HOLD_END) ? holdoff : holdoff + OW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= '0;
      dwell    <= '0;
      holdoff  <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (frame_tick && |active_mask) begin
          cand  <= low_idx;
          dwell <= DW'(1);
          state <= (DWELL_FRAMES == 1) ? REPORT : TRACK;
        end
        TRACK: if (frame_tick) begin
          if (active_mask[cand]) begin
            dwell <= dwell + DW'(1);
            if (dwell + DW'(1) == DWELL_END) state <= REPORT;
          end else begin
            dwell <= '0;
            state <= IDLE;
          end
        end
        REPORT: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= 8'(cand) + 8'd1;
          holdoff  <= '0;
          state    <= HOLDOFF;
        end
        HOLDOFF: if (frame_tick) begin
          holdoff <= hold_nxt;
          if (hold_nxt == HOLD_END) begin
`ifdef ZONE_DWELL_REPEAT_EN
            state <= active_mask[cand] ? REPORT : IDLE;
`else
            if (!active_mask[cand]) state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
